// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract with round-to-nearest-even and a start/done handshake.
// Works through one FSM state per cycle; NORM left-shifts one bit per cycle.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   restart_n,
    input  logic                   start,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   done,
    output logic                   busy,
    output logic [3:0]             flags
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int M      = MAN_W + 5;  // {carry, hidden, man, G, R, S}
    localparam int SH_MAX = MAN_W + 3;
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     opa_q, opa_d, opb_q, opb_d;
    logic             sign_q, sign_d, sub_q, sub_d;
    logic [EXP_W:0]   exp_q, exp_d;
    logic [EXP_W-1:0] dif_q, dif_d;
    logic [M-1:0]     ma_q, ma_d, mb_q, mb_d;
    logic [W-1:0]     res_q, res_d, result_q, result_d;
    logic [3:0]       flg_q, flg_d, flags_q, flags_d;
    logic             done_q, done_d;

    logic             sa, sb, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb, rman;
    int               sh;
    logic             lost, g, r, s, inc;
    logic [M-1:0]     sum;
    logic [MAN_W+1:0] rnd;
    logic [EXP_W:0]   rexp;

    // Denormal operands are flushed to zero at decode.
    assign sa     = opa_q[W-1];
    assign sb     = opb_q[W-1];
    assign ea     = opa_q[W-2:MAN_W];
    assign eb     = opb_q[W-2:MAN_W];
    assign fa     = (ea == '0) ? '0 : opa_q[MAN_W-1:0];
    assign fb     = (eb == '0) ? '0 : opb_q[MAN_W-1:0];
    assign nan_a  = (ea == EXP_ONES) && (fa != '0);
    assign nan_b  = (eb == EXP_ONES) && (fb != '0);
    assign inf_a  = (ea == EXP_ONES) && (fa == '0);
    assign inf_b  = (eb == EXP_ONES) && (fb == '0);
    assign zero_a = (ea == '0);
    assign zero_b = (eb == '0);

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sign_d   = sign_q;
        sub_d    = sub_q;
        exp_d    = exp_q;
        dif_d    = dif_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        res_d    = res_q;
        flg_d    = flg_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;

        sh   = (int'(dif_q) > SH_MAX) ? SH_MAX : int'(dif_q);
        lost = |(mb_q & ~({M{1'b1}} << sh));
        sum  = sub_q ? (ma_q - mb_q) : (ma_q + mb_q);
        g    = ma_q[2];
        r    = ma_q[1];
        s    = ma_q[0];
        inc  = g & (r | s | ma_q[3]);
        rnd  = {1'b0, ma_q[M-2:3]} + {{(MAN_W+1){1'b0}}, inc};
        rman = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        rexp = rnd[MAN_W+1] ? exp_q + 1'b1 : exp_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = {b[W-1] ^ op, b[W-2:0]};
                    res_d   = '0;
                    flg_d   = '0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                state_d = S_PACK;
                if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
                    res_d    = QNAN;
                    flg_d[3] = 1'b1;
                end else if (inf_a) begin
                    res_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
                end else if (inf_b) begin
                    res_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
                end else if (zero_a && zero_b) begin
                    res_d = {sa & sb, {(W-1){1'b0}}};
                end else begin
                    state_d = S_ALIGN;
                    sub_d   = sa ^ sb;
                    if ({ea, fa} >= {eb, fb}) begin
                        sign_d = sa;
                        exp_d  = {1'b0, ea};
                        dif_d  = ea - eb;
                        ma_d   = {1'b0, ~zero_a, fa, 3'b000};
                        mb_d   = {1'b0, ~zero_b, fb, 3'b000};
                    end else begin
                        sign_d = sb;
                        exp_d  = {1'b0, eb};
                        dif_d  = eb - ea;
                        ma_d   = {1'b0, ~zero_b, fb, 3'b000};
                        mb_d   = {1'b0, ~zero_a, fa, 3'b000};
                    end
                end
            end
            S_ALIGN: begin
                mb_d    = (mb_q >> sh) | {{(M-1){1'b0}}, lost};
                state_d = S_ADD;
            end
            S_ADD: begin
                if (sum == '0) begin
                    res_d   = '0;
                    state_d = S_PACK;
                end else begin
                    ma_d    = sum;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (ma_q[M-1]) begin
                    ma_d    = {1'b0, ma_q[M-1:2], ma_q[1] | ma_q[0]};
                    exp_d   = exp_q + 1'b1;
                    state_d = S_ROUND;
                end else if (ma_q[M-2]) begin
                    state_d = S_ROUND;
                end else begin
                    ma_d  = ma_q << 1;
                    exp_d = exp_q - 1'b1;
                    // Dropping to exponent 0 would need a denormal; flush instead.
                    if (exp_q == {{EXP_W{1'b0}}, 1'b1}) begin
                        res_d      = {sign_q, {(W-1){1'b0}}};
                        flg_d[1:0] = 2'b11;
                        state_d    = S_PACK;
                    end
                end
            end
            S_ROUND: begin
                flg_d[0] = g | r | s;
                if (rexp >= {1'b0, EXP_ONES}) begin
                    res_d    = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
                    flg_d[2] = 1'b1;
                    flg_d[0] = 1'b1;
                end else begin
                    res_d = {sign_q, rexp[EXP_W-1:0], rman};
                end
                state_d = S_PACK;
            end
            S_PACK: begin
                result_d = res_q;
                flags_d  = flg_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!restart_n) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            exp_q    <= '0;
            dif_q    <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            res_q    <= '0;
            flg_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sign_q   <= sign_d;
            sub_q    <= sub_d;
            exp_q    <= exp_d;
            dif_q    <= dif_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            res_q    <= res_d;
            flg_q    <= flg_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;
    assign done   = done_q;
    assign busy   = (state_q != S_IDLE) || done_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq (binary32): expected result, flags and latency
// are queued at issue and compared when done pulses.
module tb_fp_addsub_seq;
    logic        clk = 1'b0;
    logic        restart_n, start, op;
    logic [31:0] a, b, result;
    logic        done, busy;
    logic [3:0]  flags;

    always #5 clk = ~clk;

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .restart_n(restart_n), .start(start), .op(op),
        .a(a), .b(b), .result(result), .done(done), .busy(busy), .flags(flags)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          n;
        int          c0;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e;
    int   checks = 0, failures = 0, cyc = 0, nid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            chk("done_expected", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                m_e = sb_q.pop_front();
                chk($sformatf("res%0d", m_e.id), result, m_e.res);
                chk($sformatf("flg%0d", m_e.id), flags, m_e.flg);
                chk($sformatf("lat%0d", m_e.id), cyc - m_e.c0, m_e.n);
            end
        end
    end

    // Waits until the DUT can accept (idle or done cycle), then launches one op.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                         input logic [31:0] eres, input logic [3:0] eflg, input int n);
        exp_t e;
        int t = 0;
        while (busy && !done && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            chk("idle_timeout", t, 0);
            return;
        end
        a = ia; b = ib; op = iop; start = 1'b1;
        e.res = eres; e.flg = eflg; e.n = n; e.c0 = cyc + 1; e.id = nid;
        nid++;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() > 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    initial begin
        restart_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        restart_n = 1'b1;
        @(negedge clk);

        // Back-to-back: each issue launches in the previous op's done cycle.
        issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 6);
        issue(32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 4'b0000, 8);
        issue(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 6);
        issue(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001, 6);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 6);
        issue(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 2);
        issue(32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 4'b0000, 4);
        issue(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 2);
        issue(32'hFF800000, 32'h40400000, 1'b0, 32'hFF800000, 4'b0000, 2);
        issue(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 2);
        issue(32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 2);
        issue(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, 6);
        issue(32'hBF800000, 32'h40000000, 1'b1, 32'hC0400000, 4'b0000, 6);
        issue(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000, 6);
        issue(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001, 6);
        issue(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 5);

        // start pulsed mid-operation must not disturb the running op.
        issue(32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 4'b0000, 8);
        @(negedge clk);
        a = 32'h7F800000; b = 32'h7F800000; op = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset while in NORM: op abandoned, outputs cleared, no done.
        a = 32'h3F800000; b = 32'h3F400000; op = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_in_norm", busy, 1);
        restart_n = 1'b0;
        @(negedge clk);
        chk("midrst_result", result, 0);
        chk("midrst_flags", flags, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        restart_n = 1'b1;
        repeat (12) @(negedge clk);

        issue(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 6);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_addsub_seq.md
# fp_addsub_seq

Parametrised multi-cycle IEEE-754-style floating-point adder/subtractor with a start/done handshake. It adds or subtracts two operands of configurable exponent and mantissa width, rounds to nearest-even, handles zero/Inf/NaN operands, and reports exception flags. It is the next-generation scalar FP add unit for the datapath and is also instantiated by the FP accumulator and dot-product sequencers.

## Interface
- `EXP_W`, default 8: exponent field width.
- `MAN_W`, default 23: stored mantissa width. Total word width is W = 1+EXP_W+MAN_W. Bias is 2^(EXP_W-1)-1.
- `clk` in 1: clock, rising edge.
- `restart_n` in 1: reset, synchronous, active-low.
- `start` in 1: sampled only in IDLE; launches an operation.
- `op` in 1: 0 = a+b, 1 = a-b. Sampled with `start`.
- `a`, `b` in W: operands. Sampled with `start`.
- `result` out W: registered result, held until the next `done`.
- `done` out 1: one-cycle pulse when `result`/`flags` update.
- `busy` out 1: high from the cycle after `start` is accepted until the `done` cycle, inclusive.
- `flags` out 4: {invalid, overflow, underflow, inexact}, updated with `done`, held.

## Operation
- Denormal inputs (exp=0) are flushed to signed zero. Outputs are never denormal.
- Subtraction inverts the sign of b at capture.
- FSM states: IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, PACK.
- IDLE: on `start`, capture a, b, op and go to UNPACK. `start` while busy is ignored.
- UNPACK:
  - Special cases go straight to PACK.
  - Either operand NaN, or Inf+(-Inf), gives quiet NaN: sign 0, exp all-ones, mantissa MSB 1, rest 0. Sets invalid.
  - A single Inf, or same-sign Infs, gives that Inf.
  - Both zero gives +0, or -0 if both are -0.
  - Otherwise, order the operands so that {exp,man} of the first is >= the second. d = exp difference.
- ALIGN:
  - Internal mantissa is {carry, hidden, MAN_W bits, G, R, S}.
  - Right-shift the smaller operand by min(d, MAN_W+3). S is the OR of all bits shifted out.
- ADD:
  - Same signs: add magnitudes.
  - Different signs: larger minus smaller.
  - Result sign is the sign of the larger operand.
  - An exactly zero difference gives +0 and goes to PACK.
- NORM:
  - Carry set: shift right 1 (S |= shifted bit), exp+1, then go to ROUND.
  - Hidden bit set: go to ROUND.
  - Otherwise: shift left 1 and exp-1, one bit per cycle. Stay in NORM.
  - If exp reaches 0: the result is signed zero, set underflow and inexact, and go to PACK.
- ROUND:
  - Increment when G & (R | S | LSB).
  - inexact = G|R|S.
  - If the mantissa overflows, shift right and exp+1.
  - If exp = all-ones: the result is signed Inf, set overflow and inexact.
- PACK: register `result` and `flags`, pulse `done`, return to IDLE.

## Timing
- Edge 0 is the edge sampling `start`=1 in IDLE. `done` is high in the cycle after edge N.
- Special-case path: N = 2.
- Exact-zero difference: N = 4.
- Normal path: N = 6 + L, where L is the number of left-shift cycles in NORM (0..MAN_W+2).
- A new `start` is accepted in the cycle `done` is high.
- `restart_n` low at any edge, including mid-operation:
  - FSM goes to IDLE and the operation is abandoned.
  - `result`, `flags`, `done` and `busy` all become 0.
  - Takes priority over `start`.
- Outputs are unknown-free from the first reset edge.

## Test plan
- Add, EXP_W=8/MAN_W=23: a=0x3F800000, b=0x40000000, op=0 -> result 0x40400000, flags 0, `done` after edge 6.
- Subtract with normalisation: a=0x3F800000, b=0x3F400000, op=1 -> result 0x3E800000, L=2, `done` after edge 8.
- Rounding:
  - 0x3F800000 + 0x33800000 (tie, even) -> 0x3F800000, inexact=1.
  - 0x3F800000 + 0x33800001 -> 0x3F800001, inexact=1.
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags 4'b0101.
- Specials:
  - 0x7F800000 - 0x7F800000 -> 0x7FC00000, invalid=1, `done` after edge 2.
  - 0x40490FDB - 0x40490FDB -> 0x00000000, `done` after edge 4.
- Reset and handshake:
  - Assert `restart_n`=0 during NORM -> all outputs 0 next cycle, no `done`.
  - `start` pulsed while busy -> ignored.
  - Back-to-back `start` in the `done` cycle -> second result correct.
